// File: rtl/branch_pkg.sv
// Shared opcode constants, BHT counter encodings and the saturating counter step
// used by the branch resolve unit and its history table.
package branch_pkg;

  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_BLEZ   = 6'd6;
  localparam logic [5:0] OP_BGTZ   = 6'd7;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  // Counters stick at SNT/ST instead of wrapping, so one odd outcome never flips a strong bias.
  function automatic ctr_t ctrNext(input ctr_t cur, input logic taken);
    ctr_t nxt;
    if (taken) nxt = (cur == ST) ? ST : ctr_t'(cur + 2'd1);
    else       nxt = (cur == SNT) ? SNT : ctr_t'(cur - 2'd1);
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table of 2-bit saturating counters: one fetch read port, one
// resolve read port and one saturating-update write port. No read/write bypass.
module bht_table
  import branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX_W-1:0] i_fetchIdx,
  output logic [1:0]       o_fetchCtr,
  input  logic [IDX_W-1:0] i_rdIdx,
  output logic [1:0]       o_rdCtr,
  input  logic             i_wrEn,
  input  logic [IDX_W-1:0] i_wrIdx,
  input  logic             i_wrTaken
);

  localparam int ENTRIES = 1 << IDX_W;

  ctr_t r_ctr [ENTRIES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= WNT;
    end else if (i_wrEn) begin
      r_ctr[i_wrIdx] <= ctrNext(r_ctr[i_wrIdx], i_wrTaken);
    end
  end

  assign o_fetchCtr = r_ctr[i_fetchIdx];
  assign o_rdCtr    = r_ctr[i_rdIdx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered MIPS branch resolver with a 2-bit BHT predictor and mispredict flag.
// Define BRANCH_STATS_EN to add the BrCount/MissCount statistics ports.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_IDX_W = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [5:0]        Opcode,
  input  logic              IBit16,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [PC_W-1:0]   BranchPC,
  input  logic [PC_W-1:0]   FetchPC,
  output logic              FetchPredTaken,
  output logic              BrValid,
  output logic              BrTaken,
  output logic              BrPredTaken,
  output logic              Mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [PC_W-1:0]   BrCount,
  output logic [PC_W-1:0]   MissCount
`endif
);

  logic                 w_isBrOp;
  logic                 w_cond;
  logic                 w_isBr;
  logic                 w_update;
  logic                 w_aNeg;
  logic                 w_aZero;
  logic [BHT_IDX_W-1:0] w_branchIdx;
  logic [BHT_IDX_W-1:0] w_fetchIdx;
  logic [1:0]           w_fetchCtr;
  logic [1:0]           w_branchCtr;
  logic                 w_unusedBits;

  logic r_brValid;
  logic r_brTaken;
  logic r_brPred;
  logic r_mispredict;

  assign w_branchIdx = BranchPC[BHT_IDX_W+1:2];
  assign w_fetchIdx  = FetchPC[BHT_IDX_W+1:2];
  assign w_aNeg      = A[DATA_W-1];
  assign w_aZero     = (A == '0);

  // Single-operand branches test rs against zero only; rt is deliberately ignored.
  always_comb begin
    w_isBrOp = 1'b0;
    w_cond   = 1'b0;
    case (Opcode)
      OP_BEQ:    begin w_isBrOp = 1'b1; w_cond = (A == B);               end
      OP_BNE:    begin w_isBrOp = 1'b1; w_cond = (A != B);               end
      OP_REGIMM: begin w_isBrOp = 1'b1; w_cond = IBit16 ? ~w_aNeg : w_aNeg; end
      OP_BLEZ:   begin w_isBrOp = 1'b1; w_cond = w_aNeg | w_aZero;       end
      OP_BGTZ:   begin w_isBrOp = 1'b1; w_cond = ~w_aNeg & ~w_aZero;     end
      default:   begin w_isBrOp = 1'b0; w_cond = 1'b0;                   end
    endcase
  end

  assign w_isBr   = Valid & ~Flush & w_isBrOp;
  assign w_update = w_isBr & ~Stall;

  bht_table #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_fetchIdx (w_fetchIdx),
    .o_fetchCtr (w_fetchCtr),
    .i_rdIdx    (w_branchIdx),
    .o_rdCtr    (w_branchCtr),
    .i_wrEn     (w_update),
    .i_wrIdx    (w_branchIdx),
    .i_wrTaken  (w_cond)
  );

  // Result registers: the prediction captured is the pre-update counter MSB.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_brValid    <= 1'b0;
      r_brTaken    <= 1'b0;
      r_brPred     <= 1'b0;
      r_mispredict <= 1'b0;
    end else if (!Stall) begin
      r_brValid    <= w_isBr;
      r_brTaken    <= w_isBr & w_cond;
      r_brPred     <= w_isBr & w_branchCtr[1];
      r_mispredict <= w_isBr & (w_cond ^ w_branchCtr[1]);
    end
  end

  assign FetchPredTaken = w_fetchCtr[1];
  assign BrValid        = r_brValid;
  assign BrTaken        = r_brTaken;
  assign BrPredTaken    = r_brPred;
  assign Mispredict     = r_mispredict;

`ifdef BRANCH_STATS_EN
  logic [PC_W-1:0] r_brCount;
  logic [PC_W-1:0] r_missCount;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_brCount   <= '0;
      r_missCount <= '0;
    end else if (!Stall) begin
      if (r_brValid)    r_brCount   <= r_brCount + 1'b1;
      if (r_mispredict) r_missCount <= r_missCount + 1'b1;
    end
  end

  assign BrCount   = r_brCount;
  assign MissCount = r_missCount;
`endif

  // PC bits outside the index and the counter LSBs are intentionally unused.
  assign w_unusedBits = ^{BranchPC, FetchPC, w_fetchCtr[0], w_branchCtr[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default build; stats
// ports are connected and checked when BRANCH_STATS_EN is defined).
module tb_branch_resolve_unit;

  logic        Clk;
  logic        Rst;
  logic        Valid;
  logic        Stall;
  logic        Flush;
  logic [5:0]  Opcode;
  logic        IBit16;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] BranchPC;
  logic [31:0] FetchPC;
  logic        FetchPredTaken;
  logic        BrValid;
  logic        BrTaken;
  logic        BrPredTaken;
  logic        Mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0] BrCount;
  logic [31:0] MissCount;
`endif

  int cmpCount  = 0;
  int missCount = 0;

  branch_resolve_unit #(
    .DATA_W(32), .PC_W(32), .BHT_IDX_W(6)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Valid          (Valid),
    .Stall          (Stall),
    .Flush          (Flush),
    .Opcode         (Opcode),
    .IBit16         (IBit16),
    .A              (A),
    .B              (B),
    .BranchPC       (BranchPC),
    .FetchPC        (FetchPC),
    .FetchPredTaken (FetchPredTaken),
    .BrValid        (BrValid),
    .BrTaken        (BrTaken),
    .BrPredTaken    (BrPredTaken),
    .Mispredict     (Mispredict)
`ifdef BRANCH_STATS_EN
    ,
    .BrCount        (BrCount),
    .MissCount      (MissCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one ID-stage instruction and let it be sampled; Valid stays high for back-to-back use.
  task automatic applyStimulus(input logic [5:0] op, input logic ib,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc);
    Valid = 1'b1; Opcode = op; IBit16 = ib; A = a; B = b; BranchPC = pc;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset;
    Rst = 1'b1; Valid = 1'b0; Stall = 1'b0; Flush = 1'b0; Opcode = 6'd0;
    IBit16 = 1'b0; A = '0; B = '0; BranchPC = '0; FetchPC = 32'h0;
    #23;
    Rst = 1'b0;
    @(posedge Clk); #1;
    cmpCount++; if (FetchPredTaken !== 1'b0) begin missCount++; $display("[TB] FAIL reset_fetch got %b want 0", FetchPredTaken); end
    cmpCount++; if (BrValid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_brvalid got %b want 0", BrValid); end
    cmpCount++; if (BrTaken !== 1'b0) begin missCount++; $display("[TB] FAIL reset_brtaken got %b want 0", BrTaken); end
    cmpCount++; if (BrPredTaken !== 1'b0) begin missCount++; $display("[TB] FAIL reset_brpred got %b want 0", BrPredTaken); end
    cmpCount++; if (Mispredict !== 1'b0) begin missCount++; $display("[TB] FAIL reset_mispredict got %b want 0", Mispredict); end
  endtask

  task automatic test_beq;
    FetchPC = 32'h40;
    Valid = 1'b1; Opcode = 6'd4; A = 32'h5; B = 32'h5; BranchPC = 32'h40;
    #1;
    cmpCount++; if (FetchPredTaken !== 1'b0) begin missCount++; $display("[TB] FAIL beq_fetch_pre got %b want 0", FetchPredTaken); end
    applyStimulus(6'd4, 1'b0, 32'h5, 32'h5, 32'h40);
    Valid = 1'b0;
    cmpCount++; if (BrValid !== 1'b1) begin missCount++; $display("[TB] FAIL beq_brvalid got %b want 1", BrValid); end
    cmpCount++; if (BrTaken !== 1'b1) begin missCount++; $display("[TB] FAIL beq_brtaken got %b want 1", BrTaken); end
    cmpCount++; if (BrPredTaken !== 1'b0) begin missCount++; $display("[TB] FAIL beq_brpred got %b want 0", BrPredTaken); end
    cmpCount++; if (Mispredict !== 1'b1) begin missCount++; $display("[TB] FAIL beq_mispredict got %b want 1", Mispredict); end
    cmpCount++; if (FetchPredTaken !== 1'b1) begin missCount++; $display("[TB] FAIL beq_fetch_post got %b want 1", FetchPredTaken); end
  endtask

  // Back-to-back BNEs on index 32 drive the counter into both saturation limits.
  task automatic test_saturation;
    logic [4:0] expPred;
    logic [3:0] expDown;
    expPred = 5'b11110;
    expDown = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(6'd5, 1'b0, 32'h1, 32'h2, 32'h80);
      cmpCount++; if (BrTaken !== 1'b1) begin missCount++; $display("[TB] FAIL sat_up_taken[%0d] got %b want 1", i, BrTaken); end
      cmpCount++; if (BrPredTaken !== expPred[i]) begin missCount++; $display("[TB] FAIL sat_up_pred[%0d] got %b want %b", i, BrPredTaken, expPred[i]); end
      cmpCount++; if (Mispredict !== ~expPred[i]) begin missCount++; $display("[TB] FAIL sat_up_misp[%0d] got %b want %b", i, Mispredict, ~expPred[i]); end
    end
    FetchPC = 32'h183;
    #1;
    cmpCount++; if (FetchPredTaken !== 1'b1) begin missCount++; $display("[TB] FAIL sat_alias_fetch got %b want 1", FetchPredTaken); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(6'd5, 1'b0, 32'h3, 32'h3, 32'h80);
      cmpCount++; if (BrTaken !== 1'b0) begin missCount++; $display("[TB] FAIL sat_dn_taken[%0d] got %b want 0", i, BrTaken); end
      cmpCount++; if (BrPredTaken !== expDown[i]) begin missCount++; $display("[TB] FAIL sat_dn_pred[%0d] got %b want %b", i, BrPredTaken, expDown[i]); end
      if (i == 0) begin
        FetchPC = 32'h80; #1;
        cmpCount++; if (FetchPredTaken !== 1'b1) begin missCount++; $display("[TB] FAIL sat_dn_fetch2 got %b want 1", FetchPredTaken); end
      end
    end
    applyStimulus(6'd5, 1'b0, 32'h1, 32'h2, 32'h80);
    Valid = 1'b0;
    cmpCount++; if (BrPredTaken !== 1'b0) begin missCount++; $display("[TB] FAIL sat_low_pred got %b want 0", BrPredTaken); end
    cmpCount++; if (Mispredict !== 1'b1) begin missCount++; $display("[TB] FAIL sat_low_misp got %b want 1", Mispredict); end
    cmpCount++; if (FetchPredTaken !== 1'b0) begin missCount++; $display("[TB] FAIL sat_low_fetch got %b want 0", FetchPredTaken); end
  endtask

  task automatic test_compare_zero;
    logic [5:0]  vOp    [10];
    logic        vIb    [10];
    logic [31:0] vA     [10];
    logic [31:0] vB     [10];
    logic [31:0] vPc    [10];
    logic        vValid [10];
    logic        vTaken [10];
    vOp = '{6'd1, 6'd1, 6'd1, 6'd6, 6'd6, 6'd7, 6'd7, 6'd7, 6'd2, 6'd6};
    vIb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vA  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF};
    vB  = '{32'h7, 32'h0, 32'h5, 32'h5, 32'h5, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0};
    vPc = '{32'hC0, 32'hC4, 32'hC8, 32'hD0, 32'hD4, 32'hE0, 32'hE4, 32'hE8, 32'hF0, 32'hD8};
    vValid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vTaken = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vOp[i], vIb[i], vA[i], vB[i], vPc[i]);
      cmpCount++; if (BrValid !== vValid[i]) begin missCount++; $display("[TB] FAIL cmp_valid[%0d] got %b want %b", i, BrValid, vValid[i]); end
      cmpCount++; if (BrTaken !== vTaken[i]) begin missCount++; $display("[TB] FAIL cmp_taken[%0d] got %b want %b", i, BrTaken, vTaken[i]); end
    end
    Valid = 1'b0;
  endtask

  task automatic test_stall_flush;
    applyStimulus(6'd4, 1'b0, 32'h9, 32'h9, 32'h10);
    Stall = 1'b1;
    applyStimulus(6'd4, 1'b0, 32'h1, 32'h2, 32'h10);
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    @(posedge Clk); #1;
    FetchPC = 32'h10; #1;
    cmpCount++; if (BrValid !== 1'b1) begin missCount++; $display("[TB] FAIL stall_brvalid got %b want 1", BrValid); end
    cmpCount++; if (BrTaken !== 1'b1) begin missCount++; $display("[TB] FAIL stall_brtaken got %b want 1", BrTaken); end
    cmpCount++; if (BrPredTaken !== 1'b0) begin missCount++; $display("[TB] FAIL stall_brpred got %b want 0", BrPredTaken); end
    cmpCount++; if (Mispredict !== 1'b1) begin missCount++; $display("[TB] FAIL stall_mispredict got %b want 1", Mispredict); end
    cmpCount++; if (FetchPredTaken !== 1'b1) begin missCount++; $display("[TB] FAIL stall_fetch got %b want 1", FetchPredTaken); end
    Stall = 1'b0; Flush = 1'b1;
    applyStimulus(6'd4, 1'b0, 32'h1, 32'h2, 32'h10);
    Flush = 1'b0; Valid = 1'b0;
    cmpCount++; if (BrValid !== 1'b0) begin missCount++; $display("[TB] FAIL flush_brvalid got %b want 0", BrValid); end
    cmpCount++; if (Mispredict !== 1'b0) begin missCount++; $display("[TB] FAIL flush_mispredict got %b want 0", Mispredict); end
    cmpCount++; if (FetchPredTaken !== 1'b1) begin missCount++; $display("[TB] FAIL flush_fetch got %b want 1", FetchPredTaken); end
  endtask

  task automatic test_async_reset;
    applyStimulus(6'd4, 1'b0, 32'h7, 32'h7, 32'h40);
    applyStimulus(6'd4, 1'b0, 32'h7, 32'h7, 32'h44);
    Valid = 1'b0;
    FetchPC = 32'h40; #1;
    cmpCount++; if (Mispredict !== 1'b1) begin missCount++; $display("[TB] FAIL arst_pre_misp got %b want 1", Mispredict); end
    cmpCount++; if (FetchPredTaken !== 1'b1) begin missCount++; $display("[TB] FAIL arst_pre_fetch got %b want 1", FetchPredTaken); end
    #1 Rst = 1'b1;
    #1;
    cmpCount++; if (Mispredict !== 1'b0) begin missCount++; $display("[TB] FAIL arst_misp got %b want 0", Mispredict); end
    cmpCount++; if (BrValid !== 1'b0) begin missCount++; $display("[TB] FAIL arst_brvalid got %b want 0", BrValid); end
    cmpCount++; if (FetchPredTaken !== 1'b0) begin missCount++; $display("[TB] FAIL arst_fetch got %b want 0", FetchPredTaken); end
`ifdef BRANCH_STATS_EN
    cmpCount++; if (BrCount !== 32'h0) begin missCount++; $display("[TB] FAIL arst_brcount got %0d want 0", BrCount); end
    cmpCount++; if (MissCount !== 32'h0) begin missCount++; $display("[TB] FAIL arst_misscount got %0d want 0", MissCount); end
`endif
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_beq();
    test_saturation();
    test_compare_zero();
    test_stall_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, missCount);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
